// File: rtl/repadd_mul_pkg.sv
// ---------------------------------------------------------------------------
// repadd_mul_pkg
// Shared definitions for the repeated-addition multiplier slice.
//   DEFAULT_WIDTH : default operand/product width in bits
//   state_e       : FSM state encoding (IDLE=0, LOAD=1, CHECK=2, ADD=3, DONE=4)
//   isBusyState   : true for the states in which the block reports busy
// No ports (package).
// ---------------------------------------------------------------------------
package repadd_mul_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        ADD   = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Busy covers everything between accepting a request and the done pulse,
    // so it can never overlap with DONE.
    function automatic logic isBusyState(input state_e s);
        return (s == LOAD) || (s == CHECK) || (s == ADD);
    endfunction

endpackage

// File: rtl/repadd_mul_if.sv
// ---------------------------------------------------------------------------
// repadd_mul_if
// Request/result bundle between a requester (master) and the multiplier
// (slave).
//   start : request a multiply (master -> slave)
//   a     : multiplicand, WIDTH bits (master -> slave)
//   b     : multiplier / iteration count, WIDTH bits (master -> slave)
//   p     : product modulo 2^WIDTH (slave -> master)
//   busy  : operation in progress (slave -> master)
//   done  : one-cycle completion pulse (slave -> master)
//   ovf   : sticky carry-out flag, only with REPADD_MUL_OVF_EN defined
// Configuration macro: REPADD_MUL_OVF_EN
// ---------------------------------------------------------------------------
interface repadd_mul_if
    import repadd_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] p;
    logic             busy;
    logic             done;
`ifdef REPADD_MUL_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input p, busy, done, ovf);
    modport slave  (input start, a, b, output p, busy, done, ovf);
`else
    modport master (output start, a, b, input p, busy, done);
    modport slave  (input start, a, b, output p, busy, done);
`endif

endinterface

// File: rtl/eqz_detect.sv
// ---------------------------------------------------------------------------
// eqz_detect
// Purely combinational zero detector.
//   WIDTH : width of the checked value
//   z     : value to test (input)
//   eqz   : 1 when z == 0 (output)
// ---------------------------------------------------------------------------
module eqz_detect #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] z,
    output logic             eqz
);

    assign eqz = (z == '0);

endmodule

// File: rtl/repadd_mul.sv
// ---------------------------------------------------------------------------
// repadd_mul
// Multiplier built from repeated addition: p = a * b (mod 2^WIDTH), one add
// per CHECK/ADD pair, so latency from start sample to done is 3 + 2*b.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : repadd_mul_if.slave (start, a, b in; p, busy, done[, ovf] out)
// Configuration macro: REPADD_MUL_OVF_EN adds the sticky ovf output, set
// whenever an accumulation step carries out of WIDTH bits.
// ---------------------------------------------------------------------------
module repadd_mul
    import repadd_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    repadd_mul_if.slave     bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             b_zero;
`ifdef REPADD_MUL_OVF_EN
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum_w;
`endif

    // Zero flag on the remaining iteration count decides CHECK -> DONE.
    eqz_detect #(
        .WIDTH (WIDTH)
    ) u_eqz (
        .z   (b_q),
        .eqz (b_zero)
    );

`ifdef REPADD_MUL_OVF_EN
    // One extra bit on the adder exposes the carry for the sticky flag.
    assign sum_w = {1'b0, p_q} + {1'b0, a_q};
`endif

    // Next-state and datapath decode. Start only matters in IDLE, so a
    // request arriving in any other state (including DONE) is simply dropped.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
`ifdef REPADD_MUL_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                a_d     = bus.a;
                b_d     = bus.b;
                p_d     = '0;
`ifdef REPADD_MUL_OVF_EN
                ovf_d   = 1'b0;
`endif
                state_d = CHECK;
            end
            CHECK: begin
                state_d = b_zero ? DONE : ADD;
            end
            ADD: begin
`ifdef REPADD_MUL_OVF_EN
                p_d     = sum_w[WIDTH-1:0];
                ovf_d   = ovf_q | sum_w[WIDTH];
`else
                p_d     = p_q + a_q;
`endif
                b_d     = b_q - WIDTH'(1);
                state_d = CHECK;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they are registered
    // alongside the state and line up with it cycle for cycle.
    always_comb begin
        busy_d = isBusyState(state_d);
        done_d = (state_d == DONE);
    end

    // Single state register for FSM, datapath and registered outputs; reset
    // clears everything immediately, even mid-operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef REPADD_MUL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef REPADD_MUL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.p    = p_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef REPADD_MUL_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_repadd_mul.sv
// ---------------------------------------------------------------------------
// tb_repadd_mul
// Directed self-checking bench for repadd_mul (WIDTH = 32). Cycle 0 is the
// cycle in which start is high; cycle k is observed 1 time unit after the
// k-th following rising edge.
// Configuration macro: REPADD_MUL_OVF_EN enables the ovf checks.
// ---------------------------------------------------------------------------
module tb_repadd_mul;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    repadd_mul_if #(.WIDTH(32)) bus ();

    repadd_mul #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request starting in the current cycle (caller sits at
    // posedge+1) and records what the DUT does over maxCycles cycles.
    // restartAt re-asserts start for one cycle at that cycle (-1 = never).
    task automatic applyStimulus(
        input  logic [31:0] aIn,
        input  logic [31:0] bIn,
        input  int          restartAt,
        input  int          maxCycles,
        output int          doneCycle,
        output int          doneCount,
        output int          busyCount,
        output int          firstBusy,
        output int          lastBusy,
        output int          overlap,
        output logic [31:0] pAtDone,
        output logic        ovfAtDone
    );
        doneCycle = -1;
        doneCount = 0;
        busyCount = 0;
        firstBusy = -1;
        lastBusy  = -1;
        overlap   = 0;
        pAtDone   = 32'hDEAD_BEEF;
        ovfAtDone = 1'bx;
        bus.a     = aIn;
        bus.b     = bIn;
        bus.start = 1'b1;
        for (int c = 1; c <= maxCycles; c++) begin
            @(posedge clk);
            #1;
            bus.start = (c == restartAt);
            if (bus.busy === 1'b1) begin
                busyCount++;
                if (firstBusy < 0) firstBusy = c;
                lastBusy = c;
            end
            if (bus.busy === 1'b1 && bus.done === 1'b1) overlap++;
            if (bus.done === 1'b1) begin
                doneCount++;
                if (doneCycle < 0) begin
                    doneCycle = c;
                    pAtDone   = bus.p;
`ifdef REPADD_MUL_OVF_EN
                    ovfAtDone = bus.ovf;
`else
                    ovfAtDone = 1'b0;
`endif
                end
            end
        end
        bus.start = 1'b0;
    endtask

    // Reset held 2 cycles, then 10 idle cycles with start low.
    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (bus.p !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_hold: p=%0h busy=%b done=%b, want p=0 busy=0 done=0",
                     bus.p, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            compared++;
            if (bus.p !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL reset_idle[%0d]: p=%0h busy=%b done=%b, want 0/0/0",
                         c, bus.p, bus.busy, bus.done);
            end
        end
    endtask

    // 7 * 3: done at 9, busy 1..8, then p held after DONE.
    task automatic test_basic();
        int dc, dn, bc, fb, lb, ov;
        logic [31:0] pd;
        logic of;
        applyStimulus(32'd7, 32'd3, -1, 14, dc, dn, bc, fb, lb, ov, pd, of);
        compared++;
        if (dc !== 9) begin mismatched++; $display("[TB] FAIL basic_latency: got %0d want 9", dc); end
        compared++;
        if (pd !== 32'd21) begin mismatched++; $display("[TB] FAIL basic_product: got %0d want 21", pd); end
        compared++;
        if (fb !== 1 || lb !== 8 || bc !== 8) begin
            mismatched++;
            $display("[TB] FAIL basic_busy: first=%0d last=%0d count=%0d want 1/8/8", fb, lb, bc);
        end
        compared++;
        if (dn !== 1 || ov !== 0) begin
            mismatched++;
            $display("[TB] FAIL basic_done_pulse: doneCycles=%0d overlap=%0d want 1/0", dn, ov);
        end
        compared++;
        if (bus.p !== 32'd21) begin mismatched++; $display("[TB] FAIL basic_p_hold: got %0d want 21", bus.p); end
    endtask

    // Operand edge cases, including wrap-around of the product.
    task automatic test_edge_operands();
        int dc, dn, bc, fb, lb, ov;
        logic [31:0] pd;
        logic of;
        applyStimulus(32'hFFFF_FFFF, 32'd0, -1, 8, dc, dn, bc, fb, lb, ov, pd, of);
        compared++;
        if (dc !== 3 || pd !== 32'd0 || bc !== 2) begin
            mismatched++;
            $display("[TB] FAIL zero_b: done=%0d p=%0h busy=%0d want 3/0/2", dc, pd, bc);
        end
        applyStimulus(32'd0, 32'd5, -1, 17, dc, dn, bc, fb, lb, ov, pd, of);
        compared++;
        if (dc !== 13 || pd !== 32'd0 || bc !== 12) begin
            mismatched++;
            $display("[TB] FAIL zero_a: done=%0d p=%0h busy=%0d want 13/0/12", dc, pd, bc);
        end
        applyStimulus(32'hFFFF_FFFF, 32'd3, -1, 13, dc, dn, bc, fb, lb, ov, pd, of);
        compared++;
        if (dc !== 9 || pd !== 32'hFFFF_FFFD) begin
            mismatched++;
            $display("[TB] FAIL wrap_product: done=%0d p=%0h want 9/fffffffd", dc, pd);
        end
        applyStimulus(32'd123, 32'd1, -1, 9, dc, dn, bc, fb, lb, ov, pd, of);
        compared++;
        if (dc !== 5 || pd !== 32'd123) begin
            mismatched++;
            $display("[TB] FAIL single_iter: done=%0d p=%0d want 5/123", dc, pd);
        end
    endtask

    // Start re-pulsed while busy and while in DONE: both must be dropped.
    task automatic test_back_to_back();
        int dc, dn, bc, fb, lb, ov;
        logic [31:0] pd;
        logic of;
        applyStimulus(32'd5, 32'd4, 4, 16, dc, dn, bc, fb, lb, ov, pd, of);
        compared++;
        if (dc !== 11 || pd !== 32'd20) begin
            mismatched++;
            $display("[TB] FAIL restart_busy: done=%0d p=%0d want 11/20", dc, pd);
        end
        compared++;
        if (dn !== 1 || bc !== 10 || ov !== 0) begin
            mismatched++;
            $display("[TB] FAIL restart_queued: doneCycles=%0d busy=%0d overlap=%0d want 1/10/0", dn, bc, ov);
        end
        applyStimulus(32'd9, 32'd0, 3, 8, dc, dn, bc, fb, lb, ov, pd, of);
        compared++;
        if (dc !== 3 || dn !== 1 || bc !== 2) begin
            mismatched++;
            $display("[TB] FAIL restart_in_done: done=%0d doneCycles=%0d busy=%0d want 3/1/2", dc, dn, bc);
        end
    endtask

    // Reset pulsed at cycle 6 of a 5 * 4 run: immediate clear, no done.
    task automatic test_midop_reset();
        int doneSeen;
        int busySeen;
        bus.a     = 32'd5;
        bus.b     = 32'd4;
        bus.start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        compared++;
        if (bus.p !== 32'd10 || bus.busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midop_pre_reset: p=%0d busy=%b want 10/1", bus.p, bus.busy);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (bus.p !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midop_reset_clear: p=%0h busy=%b done=%b want 0/0/0", bus.p, bus.busy, bus.done);
        end
`ifdef REPADD_MUL_OVF_EN
        compared++;
        if (bus.ovf !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midop_reset_ovf: got %b want 0", bus.ovf);
        end
`endif
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        doneSeen = 0;
        busySeen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) doneSeen++;
            if (bus.busy === 1'b1) busySeen++;
        end
        compared++;
        if (doneSeen !== 0 || busySeen !== 0 || bus.p !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL midop_after_reset: done=%0d busy=%0d p=%0h want 0/0/0", doneSeen, busySeen, bus.p);
        end
    endtask

`ifdef REPADD_MUL_OVF_EN
    // Carry out of the accumulator sets ovf; next LOAD clears it.
    task automatic test_overflow();
        int dc, dn, bc, fb, lb, ov;
        logic [31:0] pd;
        logic of;
        applyStimulus(32'h8000_0000, 32'd2, -1, 10, dc, dn, bc, fb, lb, ov, pd, of);
        compared++;
        if (dc !== 7 || pd !== 32'd0 || of !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ovf_set: done=%0d p=%0h ovf=%b want 7/0/1", dc, pd, of);
        end
        applyStimulus(32'd1, 32'd1, -1, 8, dc, dn, bc, fb, lb, ov, pd, of);
        compared++;
        if (dc !== 5 || pd !== 32'd1 || of !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ovf_clear: done=%0d p=%0h ovf=%b want 5/1/0", dc, pd, of);
        end
    endtask
`endif

    // Scenario sequence and summary.
    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_basic();
        test_edge_operands();
        test_back_to_back();
`ifdef REPADD_MUL_OVF_EN
        test_overflow();
`endif
        test_midop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/repadd_mul.md
REPADD_MUL -- requirements
Module: repadd_mul

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and product width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a multiply; sampled in IDLE only.
REQ-005 The block SHALL have port a, input, WIDTH bits: multiplicand; captured in LOAD.
REQ-006 The block SHALL have port b, input, WIDTH bits: multiplier (iteration count); captured in LOAD.
REQ-007 The block SHALL have port p, output, WIDTH bits: product, modulo 2^WIDTH.
REQ-008 The block SHALL have port busy, output, 1 bit: high in LOAD, CHECK and ADD.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse in DONE.
REQ-010 The block SHALL have port ovf, output, 1 bit, present only when the macro in REQ-024 is defined.

Function
REQ-011 The FSM SHALL have five states: IDLE, LOAD, CHECK, ADD and DONE.
REQ-012 In IDLE, start=1 SHALL move the FSM to LOAD; start=0 SHALL hold IDLE.
REQ-013 In LOAD, the block SHALL register a into A_r and b into B_r, clear p to 0, and go to CHECK.
- a and b are sampled one cycle after start; the driver holds them stable.
REQ-014 In CHECK, the block SHALL go to DONE when the zero flag (B_r==0) is 1; otherwise it SHALL go to ADD.
REQ-015 In ADD, the block SHALL set p <= p + A_r and B_r <= B_r - 1, both truncated to WIDTH bits, and return to CHECK.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-017 Latency SHALL be exactly 3 + 2*b cycles, from the cycle start is sampled to the cycle done is high.
REQ-018 p SHALL hold its value from DONE until the next LOAD.
REQ-019 start SHALL be ignored while the FSM is outside IDLE, including in DONE; no request is queued.
REQ-020 The product SHALL be computed for operand edge cases as follows:
- b=0 gives p=0 with latency 3.
- a=0 runs b iterations and gives p=0.
REQ-021 busy and done SHALL never be high in the same cycle.

Reset
REQ-022 Asserting rst_n=0 SHALL immediately force the following, in any state including mid-operation:
- state=IDLE
- p=0, A_r=0, B_r=0
- busy=0, done=0, ovf=0
REQ-023 After rst_n is released, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-024 With REPADD_MUL_OVF_EN defined, the block SHALL provide port ovf, which behaves as follows:
- It is cleared in LOAD.
- It is set in ADD when the carry out of p + A_r is 1.
- It stays sticky until the next LOAD or reset.
REQ-025 Without REPADD_MUL_OVF_EN, port ovf and its carry logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Shared package repadd_mul_pkg SHALL hold the following:
- the FSM state typedef (3-bit encoding: IDLE=0, LOAD=1, CHECK=2, ADD=3, DONE=4)
- the default WIDTH constant
REQ-027 The zero flag SHALL come from one sub-module, eqz_detect, which has the following interface:
- WIDTH-parameterised
- input z
- output eqz = (z==0)
- purely combinational, instantiated on B_r

Verification
REQ-028 Reset then idle: rst_n low for 2 cycles, then high, with start=0 for 10 cycles -> p=0, busy=0, done=0 throughout.
REQ-029 Basic multiply: a=7, b=3, start pulsed at cycle 0 -> done high at cycle 9, p=21, busy high in cycles 1-8.
REQ-030 Zero count: a=0xFFFF_FFFF, b=0 -> done at cycle 3, p=0; a=0, b=5 -> done at cycle 13, p=0.
REQ-031 Overflow (REPADD_MUL_OVF_EN defined): a=0x8000_0000, b=2 -> p=0 and ovf=1 at done; a following a=1, b=1 run -> ovf=0, p=1.
REQ-032 Busy and mid-operation reset, in three steps:
- a=5, b=4.
- start re-pulsed at cycle 4 -> ignored; done at cycle 11, p=20.
- Repeat with rst_n pulsed low at cycle 6 -> p=0 and state IDLE immediately; no done pulse appears.
